// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with two combinational read ports,
// one writeback port and a per-register pending scoreboard for RAW hazard
// detection at issue.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   rs1, rs2 / r1, r2 read addresses / read data, ports 1 and 2
//   we, rd, wd        writeback enable, address, data (clears pending bit)
//   iss_v, iss_rd     issue request reserving iss_rd as pending
//   iss_rdy           issue accepted this cycle
//   haz1, haz2        read operand still pending (RAW hazard)
//   pend_cnt          registered number of pending registers
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_rdy,
  output logic            haz1,
  output logic            haz2,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] mem [NREG];
  // Bit 0 exists only so the scoreboard can be indexed by any address; it is
  // held at 0 so register 0 is never pending.
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  logic            wr_en;
  logic            set_en;
  logic            set_hit;
  logic            clr_hit;
  logic            byp1;
  logic            byp2;
  logic [AW:0]     cnt_nxt;

  assign wr_en  = we & (rd != '0);
  assign set_en = iss_rdy & (iss_rd != '0);

  // Forwarding: a writeback to the register being read is visible in the
  // same cycle instead of after the edge.
  assign byp1 = (BYPASS != 0) & wr_en & (rd == rs1);
  assign byp2 = (BYPASS != 0) & wr_en & (rd == rs2);

  // A pending register may be re-issued when its writeback lands this cycle.
  assign iss_rdy = !rst & iss_v &
                   ((iss_rd == '0) | !pend[iss_rd] | (we & (rd == iss_rd)));

  always_comb begin
    r1 = '0;
    r2 = '0;
    if (!rst) begin
      if (rs1 != '0) r1 = byp1 ? wd : mem[rs1];
      if (rs2 != '0) r2 = byp2 ? wd : mem[rs2];
    end
  end

  assign haz1 = !rst & pend[rs1] & (rs1 != '0) & !byp1;
  assign haz2 = !rst & pend[rs2] & (rs2 != '0) & !byp2;

  // Set is applied after clear so a same-register set+clear leaves it pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_en)  pend_nxt[rd]     = 1'b0;
    if (set_en) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Count tracks actual bit transitions so it always equals popcount(pend):
  // a set only counts when the bit was clear, a clear only when it was set
  // and not immediately re-set by an issue to the same register.
  assign set_hit = set_en & !pend[iss_rd];
  assign clr_hit = wr_en & pend[rd] & !(set_en & (iss_rd == rd));
  assign cnt_nxt = pend_cnt + {{AW{1'b0}}, set_hit} - {{AW{1'b0}}, clr_hit};

  // ---- state update at rising clk ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_en) mem[rd] <= wd;
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, iss_rd;
  logic [XLEN-1:0] wd;
  logic            we, iss_v;

  logic [XLEN-1:0] r1, r2, r1b, r2b;
  logic            iss_rdy, haz1, haz2, iss_rdyb, haz1b, haz2b;
  logic [AW:0]     pend_cnt, pend_cntb;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2),
    .we(we), .rd(rd), .wd(wd), .iss_v(iss_v), .iss_rd(iss_rd),
    .iss_rdy(iss_rdy), .haz1(haz1), .haz2(haz2), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .r1(r1b), .r2(r2b),
    .we(we), .rd(rd), .wd(wd), .iss_v(iss_v), .iss_rd(iss_rd),
    .iss_rdy(iss_rdyb), .haz1(haz1b), .haz2(haz2b), .pend_cnt(pend_cntb)
  );

  typedef enum int {S_R1, S_R2, S_HAZ1, S_HAZ2, S_RDY, S_CNT,
                    S_R1B, S_R2B, S_HAZ1B, S_HAZ2B, S_RDYB, S_CNTB} sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [31:0] obs(sel_t s);
    case (s)
      S_R1:    return r1;
      S_R2:    return r2;
      S_HAZ1:  return {31'd0, haz1};
      S_HAZ2:  return {31'd0, haz2};
      S_RDY:   return {31'd0, iss_rdy};
      S_CNT:   return {26'd0, pend_cnt};
      S_R1B:   return r1b;
      S_R2B:   return r2b;
      S_HAZ1B: return {31'd0, haz1b};
      S_HAZ2B: return {31'd0, haz2b};
      S_RDYB:  return {31'd0, iss_rdyb};
      default: return {26'd0, pend_cntb};
    endcase
  endfunction

  task automatic push_exp(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      total++;
      assert (o === e.val) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
    end
  endtask

  task automatic idle();
    we = 1'b0; rd = '0; wd = '0;
    iss_v = 1'b0; iss_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  // Each step: inputs change on the falling edge, outputs sampled 2ns later.
  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    // Reset with activity on every input: all outputs must stay 0.
    rst = 1'b1;
    idle();
    we = 1'b1; rd = 5'd5; wd = 32'h1111_1111;
    iss_v = 1'b1; iss_rd = 5'd3;
    rs1 = 5'd5; rs2 = 5'd7;
    #2;
    push_exp("rst_r1", S_R1, 32'h0);
    push_exp("rst_r2", S_R2, 32'h0);
    push_exp("rst_rdy", S_RDY, 32'h0);
    push_exp("rst_haz1", S_HAZ1, 32'h0);
    push_exp("rst_cnt", S_CNT, 32'h0);
    push_exp("rst_rdy_nb", S_RDYB, 32'h0);
    push_exp("rst_cnt_nb", S_CNTB, 32'h0);
    check_q();
    @(posedge clk);

    // Plain write then read next cycle.
    step(); rst = 1'b0;
    we = 1'b1; rd = 5'd5; wd = 32'hDEAD_BEEF; rs1 = 5'd0;
    #2; push_exp("wr_rs0", S_R1, 32'h0); check_q();
    step(); rs1 = 5'd5;
    #2;
    push_exp("rd5", S_R1, 32'hDEAD_BEEF);
    push_exp("rd5_nb", S_R1B, 32'hDEAD_BEEF);
    push_exp("cnt_after_wr", S_CNT, 32'h0);
    check_q();

    // Same-cycle forwarding versus no forwarding.
    step(); we = 1'b1; rd = 5'd7; wd = 32'h1234_5678; rs2 = 5'd7;
    #2;
    push_exp("byp_r2", S_R2, 32'h1234_5678);
    push_exp("nobyp_r2", S_R2B, 32'h0);
    check_q();
    step(); rs2 = 5'd7;
    #2;
    push_exp("r2_after", S_R2, 32'h1234_5678);
    push_exp("r2_after_nb", S_R2B, 32'h1234_5678);
    check_q();

    // Issue r3, then hazard, duplicate issue rejected, writeback clears.
    step(); iss_v = 1'b1; iss_rd = 5'd3; rs1 = 5'd3;
    #2;
    push_exp("iss3_rdy", S_RDY, 32'h1);
    push_exp("iss3_haz_pre", S_HAZ1, 32'h0);
    check_q();
    step(); rs1 = 5'd3;
    #2;
    push_exp("haz1_r3", S_HAZ1, 32'h1);
    push_exp("haz1_r3_nb", S_HAZ1B, 32'h1);
    push_exp("cnt1", S_CNT, 32'h1);
    check_q();
    step(); iss_v = 1'b1; iss_rd = 5'd3;
    #2; push_exp("dup_iss", S_RDY, 32'h0); check_q();
    step(); rs2 = 5'd3;
    #2;
    push_exp("dup_cnt", S_CNT, 32'h1);
    push_exp("haz2_r3", S_HAZ2, 32'h1);
    check_q();
    step(); we = 1'b1; rd = 5'd3; wd = 32'h0000_00AA; rs1 = 5'd3;
    #2;
    push_exp("wb_haz1", S_HAZ1, 32'h0);
    push_exp("wb_haz1_nb", S_HAZ1B, 32'h1);
    push_exp("wb_r1", S_R1, 32'h0000_00AA);
    check_q();
    step(); rs1 = 5'd3;
    #2;
    push_exp("wb_cnt0", S_CNT, 32'h0);
    push_exp("wb_haz1_after", S_HAZ1, 32'h0);
    check_q();

    // Same-register writeback and re-issue: set wins.
    step(); iss_v = 1'b1; iss_rd = 5'd3;
    #2; check_q();
    step(); we = 1'b1; rd = 5'd3; wd = 32'h55; iss_v = 1'b1; iss_rd = 5'd3;
    #2;
    push_exp("setclr_rdy", S_RDY, 32'h1);
    push_exp("setclr_cnt_pre", S_CNT, 32'h1);
    check_q();
    step(); rs1 = 5'd3;
    #2;
    push_exp("setclr_haz", S_HAZ1, 32'h1);
    push_exp("setclr_cnt", S_CNT, 32'h1);
    check_q();

    // Set one register while clearing another: count unchanged.
    step(); we = 1'b1; rd = 5'd3; wd = 32'h66; iss_v = 1'b1; iss_rd = 5'd9;
    #2; push_exp("swap_rdy", S_RDY, 32'h1); check_q();
    step(); rs1 = 5'd9; rs2 = 5'd3;
    #2;
    push_exp("swap_cnt", S_CNT, 32'h1);
    push_exp("swap_haz1", S_HAZ1, 32'h1);
    push_exp("swap_haz2", S_HAZ2, 32'h0);
    push_exp("swap_r2", S_R2, 32'h66);
    check_q();

    // Register 0: writes ignored, issue always accepted, never pending.
    step(); we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
    iss_v = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #2;
    push_exp("z_r1", S_R1, 32'h0);
    push_exp("z_rdy", S_RDY, 32'h1);
    push_exp("z_haz1", S_HAZ1, 32'h0);
    check_q();
    step(); rs1 = 5'd0;
    #2;
    push_exp("z_r1_after", S_R1, 32'h0);
    push_exp("z_cnt", S_CNT, 32'h1);
    check_q();

    // Drain r9.
    step(); we = 1'b1; rd = 5'd9; wd = 32'h99;
    #2; check_q();
    step();
    #2; push_exp("drain_cnt", S_CNT, 32'h0); check_q();

    // Fill the scoreboard, then reset between edges.
    for (int i = 1; i < NREG; i++) begin
      step(); iss_v = 1'b1; iss_rd = AW'(i);
      #2; push_exp("fill_rdy", S_RDY, 32'h1); check_q();
    end
    step(); rs1 = 5'd5; rs2 = 5'd7;
    #2;
    push_exp("full_cnt", S_CNT, 32'(NREG - 1));
    push_exp("full_haz1", S_HAZ1, 32'h1);
    push_exp("full_cnt_nb", S_CNTB, 32'(NREG - 1));
    check_q();
    #1;
    rst = 1'b1;
    we = 1'b1; rd = 5'd5; wd = 32'h77; iss_v = 1'b1; iss_rd = 5'd3;
    #1;
    push_exp("arst_cnt", S_CNT, 32'h0);
    push_exp("arst_r1", S_R1, 32'h0);
    push_exp("arst_r2", S_R2, 32'h0);
    push_exp("arst_haz1", S_HAZ1, 32'h0);
    push_exp("arst_haz2_nb", S_HAZ2B, 32'h0);
    push_exp("arst_rdy", S_RDY, 32'h0);
    push_exp("arst_r1_nb", S_R1B, 32'h0);
    check_q();

    // First cycles after reset behave as fresh.
    step(); rst = 1'b0; rs1 = 5'd5; rs2 = 5'd7; iss_v = 1'b1; iss_rd = 5'd3;
    #2;
    push_exp("post_r1", S_R1, 32'h0);
    push_exp("post_r2", S_R2, 32'h0);
    push_exp("post_haz1", S_HAZ1, 32'h0);
    push_exp("post_rdy", S_RDY, 32'h1);
    check_q();
    step(); rs1 = 5'd3;
    #2;
    push_exp("post_cnt", S_CNT, 32'h1);
    push_exp("post_haz1_r3", S_HAZ1, 32'h1);
    check_q();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
